axi_wr_burst_master: RTL and testbench
======================================

Name: axi_wr_burst_master

Overview:
Parametrised AXI write master, successor to the single-beat AW/W bridge. It accepts write commands with burst length from the CPU/cache side and issues AW independently of W. It streams W beats with correct wlast and tracks up to MAX_OUTSTANDING un-responded bursts. B responses are reported back per burst. It sits between the cache/uncached write path and the AXI crossbar.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, W data width; strobe width is DATA_WIDTH/8
ID_WIDTH, 4, AXI ID width
AXI_ID, 1, constant value driven on awid/wid
MAX_OUTSTANDING, 4, max bursts accepted but not yet B-acknowledged (power of 2, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  write command valid
req_ready  out  1  command accepted when req_valid&&req_ready
req_addr  in  ADDR_WIDTH  burst start address
req_size  in  3  bytes per beat = 2^req_size
req_len  in  8  beats minus one (0..255)
dat_valid  in  1  user write beat valid
dat_ready  out  1  user beat consumed when dat_valid&&dat_ready
dat_data  in  DATA_WIDTH  beat data
dat_strb  in  DATA_WIDTH/8  beat byte strobes
awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  out  ID_WIDTH/ADDR_WIDTH/8/3/2/2/4/3  AXI AW payload
awvalid  out  1;  awready  in  1
wid/wdata/wstrb/wlast  out  ID_WIDTH/DATA_WIDTH/DATA_WIDTH/8/1  AXI W payload
wvalid  out  1;  wready  in  1
bid  in  ID_WIDTH;  bresp  in  2;  bvalid  in  1;  bready  out  1
wr_done  out  1  one-cycle pulse per received B response
wr_resp  out  2  bresp of that response, valid with wr_done
wr_err  out  1  sticky: set on any bresp != 2'b00, cleared only by reset
outstanding  out  clog2(MAX_OUTSTANDING)+1  bursts accepted minus B responses received

Behaviour:
- Constants: awid=wid=AXI_ID, awburst=2'b01 (INCR), awlock=0, awcache=0, awprot=0.
- Reset (async, immediate): awvalid=0, wvalid path idle, wr_done=0, wr_resp=0, wr_err=0, outstanding=0, len queue empty, beat counter=0, AW payload regs=0. In-flight bursts are dropped; no responses reported after reset.
- AW state machine, states AW_IDLE and AW_BUSY:
  - AW_IDLE: req_ready=1 iff outstanding<MAX_OUTSTANDING and len queue not full. On accept, register addr/size/len to awaddr/awsize/awlen, push req_len into len queue, outstanding+1, go to AW_BUSY.
  - AW_BUSY: awvalid=1, payload held stable, req_ready=0; on awready go to AW_IDLE. Back-to-back commands therefore issue at most one AW per 2 cycles.
- W path: len queue is a FIFO, depth MAX_OUTSTANDING, holding one awlen per burst. W may lead or lag AW; no ordering between AW and W handshakes is assumed.
  - Queue non-empty: wvalid=dat_valid, dat_ready=wready, wdata/wstrb=dat_data/dat_strb (combinational pass-through).
  - Queue empty: wvalid=0, dat_ready=0.
  - wlast=1 when beat counter == queue head. On wvalid&&wready: counter+1. If wlast, counter clears to 0 and queue pops.
  - A push and a pop in the same cycle are both performed.
- B path: bready=1 whenever outstanding>0. On bvalid&&bready, the next cycle drives wr_done=1 for one cycle with wr_resp=registered bresp, and outstanding-1. wr_err is set if bresp!=0. bid is not checked.
- outstanding: simultaneous accept and B handshake leaves the value unchanged; it never exceeds MAX_OUTSTANDING and never underflows, since bready=0 at 0.
- No 4KB-boundary or size legality checks; the caller guarantees legal bursts.

Test Plan:
- Single beat: req addr=0x1000, size=2, len=0; dat 0xDEADBEEF, strb=0xF; awready=wready=1 -> awvalid for 1 cycle with awaddr=0x1000, awlen=0, awsize=2; one W beat with wlast=1. After bvalid with bresp=0: wr_done pulse, wr_resp=0, outstanding 1->0.
- 4-beat burst, W before AW: awready held 0 for 6 cycles, len=3, wready=1 -> four W beats complete first with wlast only on beat 4; awvalid stays high and awaddr stable until awready; outstanding=1 until B.
- Outstanding limit: MAX_OUTSTANDING=4, bvalid held 0, five requests presented -> four accepted; req_ready=0 with outstanding=4. One B handshake -> fifth request accepted next cycle; outstanding stays 4.
- Simultaneous events: request accepted in the same cycle as a B handshake -> outstanding unchanged. A len queue push and pop in the same cycle -> queue count unchanged, and next burst's wlast follows its own len.
- Error response: bresp=2'b10 on the second of three bursts -> wr_resp=2 on that pulse, wr_err=1 and it stays 1 after later OKAY responses.
- Async reset mid-burst: reset asserted during beat 2 of a len=7 burst with awvalid high -> awvalid=0, wvalid=0, outstanding=0, wr_err=0 immediately, without waiting for a clk edge; after release, a fresh len=0 request completes normally.

Source files
------------

// File: rtl/axi_wr_burst_master_if.sv
// AXI write-channel bundle (AW, W, B) between a write master and the crossbar.
// The master modport drives AW/W payloads and bready; the slave side drives the ready/response signals.
interface axi_wr_burst_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic [1:0]              awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;

    logic [ID_WIDTH-1:0]     wid;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_wr_burst_master.sv
// AXI burst write master: AW issued from registered command payload, W streamed from the user beat port
// with wlast derived from a per-burst length FIFO, B responses reported per burst with a sticky error flag.
module axi_wr_burst_master #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int AXI_ID          = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [ADDR_WIDTH-1:0]                req_addr,
    input  logic [2:0]                           req_size,
    input  logic [7:0]                           req_len,
    input  logic                                 dat_valid,
    output logic                                 dat_ready,
    input  logic [DATA_WIDTH-1:0]                dat_data,
    input  logic [DATA_WIDTH/8-1:0]              dat_strb,
    axi_wr_burst_master_if.master                axi,
    output logic                                 wr_done,
    output logic [1:0]                           wr_resp,
    output logic                                 wr_err,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);

    typedef enum logic {AW_IDLE = 1'b0, AW_BUSY = 1'b1} aw_state_t;

    aw_state_t               aw_state_reg;
    logic [ADDR_WIDTH-1:0]   awaddr_reg;
    logic [2:0]              awsize_reg;
    logic [7:0]              awlen_reg;
    logic [OUT_W-1:0]        outstanding_reg;
    logic [7:0]              len_mem [MAX_OUTSTANDING];
    logic [PTR_W:0]          wr_ptr_reg;
    logic [PTR_W:0]          rd_ptr_reg;
    logic [7:0]              beat_cnt_reg;
    logic                    wr_done_reg;
    logic [1:0]              wr_resp_reg;
    logic                    wr_err_reg;

    logic       q_empty;
    logic       q_full;
    logic [7:0] len_head;
    logic       req_fire;
    logic       w_fire;
    logic       w_last_fire;
    logic       b_fire;
    logic       unused_bid;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign q_empty  = (wr_ptr_reg == rd_ptr_reg);
    assign q_full   = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign len_head = len_mem[rd_ptr_reg[PTR_W-1:0]];

    assign req_ready   = (aw_state_reg == AW_IDLE) &&
                         (outstanding_reg < OUT_W'(MAX_OUTSTANDING)) && !q_full;
    assign req_fire    = req_valid && req_ready;
    assign w_fire      = axi.wvalid && axi.wready;
    assign w_last_fire = w_fire && axi.wlast;
    assign b_fire      = axi.bvalid && axi.bready;

    assign axi.awid    = ID_WIDTH'(AXI_ID);
    assign axi.awaddr  = awaddr_reg;
    assign axi.awlen   = awlen_reg;
    assign axi.awsize  = awsize_reg;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = (aw_state_reg == AW_BUSY);

    // W beats flow straight through once at least one burst length is known.
    assign axi.wid    = ID_WIDTH'(AXI_ID);
    assign axi.wdata  = dat_data;
    assign axi.wstrb  = dat_strb;
    assign axi.wvalid = !q_empty && dat_valid;
    assign axi.wlast  = !q_empty && (beat_cnt_reg == len_head);
    assign dat_ready  = !q_empty && axi.wready;

    assign axi.bready  = (outstanding_reg != '0);
    assign unused_bid  = ^axi.bid;

    assign wr_done     = wr_done_reg;
    assign wr_resp     = wr_resp_reg;
    assign wr_err      = wr_err_reg;
    assign outstanding = outstanding_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_state_reg <= AW_IDLE;
            awaddr_reg   <= '0;
            awsize_reg   <= '0;
            awlen_reg    <= '0;
        end else begin
            case (aw_state_reg)
                AW_IDLE: begin
                    if (req_fire) begin
                        awaddr_reg   <= req_addr;
                        awsize_reg   <= req_size;
                        awlen_reg    <= req_len;
                        aw_state_reg <= AW_BUSY;
                    end
                end
                AW_BUSY: begin
                    if (axi.awready) begin
                        aw_state_reg <= AW_IDLE;
                    end
                end
                default: aw_state_reg <= AW_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            len_mem[wr_ptr_reg[PTR_W-1:0]] <= req_len;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            if (req_fire) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (w_last_fire) begin
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                beat_cnt_reg <= '0;
            end else if (w_fire) begin
                beat_cnt_reg <= beat_cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding_reg <= '0;
            wr_done_reg     <= 1'b0;
            wr_resp_reg     <= 2'b00;
            wr_err_reg      <= 1'b0;
        end else begin
            case ({req_fire, b_fire})
                2'b10:   outstanding_reg <= outstanding_reg + OUT_W'(1);
                2'b01:   outstanding_reg <= outstanding_reg - OUT_W'(1);
                default: outstanding_reg <= outstanding_reg;
            endcase
            wr_done_reg <= b_fire;
            if (b_fire) begin
                wr_resp_reg <= axi.bresp;
                if (axi.bresp != 2'b00) begin
                    wr_err_reg <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Scoreboard bench for axi_wr_burst_master: commands push expected AW/W/B items, a negedge monitor
// pops and compares them and checks handshake outputs against a small cycle model.
module tb_axi_wr_burst_master;
    localparam int MAXO = 4;

    typedef logic [42:0] aw_item_t;   // {addr, len, size}
    typedef logic [36:0] w_item_t;    // {data, strb, last}
    typedef logic [35:0] d_item_t;    // {data, strb}

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [7:0]  req_len;
    logic        dat_valid;
    logic        dat_ready;
    logic [31:0] dat_data;
    logic [3:0]  dat_strb;
    logic        wr_done;
    logic [1:0]  wr_resp;
    logic        wr_err;
    logic [2:0]  outstanding;

    axi_wr_burst_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) axi ();

    axi_wr_burst_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .AXI_ID(1), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_size(req_size), .req_len(req_len),
        .dat_valid(dat_valid), .dat_ready(dat_ready),
        .dat_data(dat_data), .dat_strb(dat_strb),
        .axi(axi),
        .wr_done(wr_done), .wr_resp(wr_resp), .wr_err(wr_err),
        .outstanding(outstanding)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    aw_item_t   exp_aw[$];
    w_item_t    exp_w[$];
    d_item_t    dat_q[$];
    logic [1:0] exp_b[$];
    logic [1:0] resp_q[$];

    int aw_cnt = 0, wl_cnt = 0, w_fire_cnt = 0, b_fire_cnt = 0;
    int m_out = 0, m_q = 0;
    bit m_busy = 0, m_done = 0, m_err = 0;
    int simul_cnt = 0, pushpop_cnt = 0;
    bit b_en = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_req(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                            input logic [1:0] resp, input logic [31:0] first_data);
        logic [31:0] d;
        logic [3:0]  s;
        logic        lst;
        bit          got;
        int          n;
        @(posedge clk); #1;
        for (int i = 0; i <= int'(len); i++) begin
            d   = (i == 0) ? first_data : $urandom;
            s   = (i == 0) ? 4'hF : 4'($urandom_range(1, 15));
            lst = (i == int'(len));
            exp_w.push_back({d, s, lst});
            dat_q.push_back({d, s});
        end
        exp_aw.push_back({addr, len, size});
        exp_b.push_back(resp);
        resp_q.push_back(resp);
        req_valid = 1'b1;
        req_addr  = addr;
        req_size  = size;
        req_len   = len;
        got = 1'b0;
        n   = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b0;
        $display("req addr=%08h len=%0d size=%0d accepted=%0d", addr, len, size, got);
        chk("req_accept", got, 1'b1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (exp_aw.size() == 0) && (exp_w.size() == 0) && (exp_b.size() == 0) && (m_out == 0);
        end
        chk("idle_reached", done, 1'b1);
    endtask

    // User data beat source.
    initial begin
        int w_popped;
        w_popped  = 0;
        dat_valid = 1'b0;
        dat_data  = '0;
        dat_strb  = '0;
        forever begin
            @(posedge clk); #2;
            if (reset) begin
                dat_q.delete();
                w_popped  = 0;
                dat_valid = 1'b0;
            end else begin
                while (w_popped < w_fire_cnt) begin
                    if (dat_q.size() > 0) dat_q.delete(0);
                    w_popped++;
                end
                if (dat_q.size() > 0) begin
                    dat_valid            = 1'b1;
                    {dat_data, dat_strb} = dat_q[0];
                end else begin
                    dat_valid = 1'b0;
                end
            end
        end
    end

    // B responder: answers a burst only once both its AW and last W beat are done.
    initial begin
        int b_issued, b_acked;
        b_issued   = 0;
        b_acked    = 0;
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        axi.bid    = 4'd1;
        forever begin
            @(posedge clk); #2;
            if (reset) begin
                axi.bvalid = 1'b0;
                b_issued   = 0;
                b_acked    = 0;
                resp_q.delete();
            end else if (axi.bvalid && b_fire_cnt > b_acked) begin
                b_acked++;
                axi.bvalid = 1'b0;
            end else if (!axi.bvalid && b_en && aw_cnt > b_issued && wl_cnt > b_issued &&
                         resp_q.size() > 0) begin
                axi.bvalid = 1'b1;
                axi.bresp  = resp_q.pop_front();
                b_issued++;
            end
        end
    end

    // Monitor: compare outputs against the model, then advance the model by this cycle's handshakes.
    initial begin
        aw_item_t a;
        w_item_t  w;
        bit acc, bf, awf, wf, wl;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_aw.delete(); exp_w.delete(); exp_b.delete();
                m_out = 0; m_q = 0; m_busy = 0; m_done = 0; m_err = 0;
                aw_cnt = 0; wl_cnt = 0; w_fire_cnt = 0; b_fire_cnt = 0;
            end else begin
                chk("outstanding", outstanding, m_out);
                chk("req_ready", req_ready, (!m_busy && m_out < MAXO && m_q < MAXO));
                chk("awvalid", axi.awvalid, m_busy);
                chk("bready", axi.bready, (m_out != 0));
                chk("wvalid", axi.wvalid, (m_q != 0 && dat_valid));
                chk("dat_ready", dat_ready, (m_q != 0 && axi.wready));
                chk("wr_done", wr_done, m_done);
                chk("wr_err", wr_err, m_err);
                awf = axi.awvalid && axi.awready;
                if (axi.awvalid) begin
                    if (exp_aw.size() == 0) begin
                        chk("aw_unexp", axi.awvalid, 1'b0);
                    end else begin
                        a = exp_aw[0];
                        chk("awaddr", axi.awaddr, a[42:11]);
                        chk("awlen", axi.awlen, a[10:3]);
                        chk("awsize", axi.awsize, a[2:0]);
                        chk("aw_const", {axi.awid, axi.awburst, axi.awlock, axi.awcache, axi.awprot},
                            {4'd1, 2'b01, 2'b00, 4'd0, 3'd0});
                        if (awf) begin
                            $display("aw addr=%08h len=%0d size=%0d", axi.awaddr, axi.awlen, axi.awsize);
                            exp_aw.delete(0);
                        end
                    end
                end
                wf = axi.wvalid && axi.wready;
                wl = 1'b0;
                if (wf) begin
                    if (exp_w.size() == 0) begin
                        chk("w_unexp", axi.wvalid, 1'b0);
                    end else begin
                        w  = exp_w[0];
                        wl = w[0];
                        $display("w data=%08h strb=%h last=%0d", axi.wdata, axi.wstrb, axi.wlast);
                        chk("wdata", axi.wdata, w[36:5]);
                        chk("wstrb", axi.wstrb, w[4:1]);
                        chk("wlast", axi.wlast, w[0]);
                        chk("wid", axi.wid, 4'd1);
                        exp_w.delete(0);
                    end
                end
                if (wr_done) begin
                    if (exp_b.size() == 0) begin
                        chk("b_unexp", wr_done, 1'b0);
                    end else begin
                        $display("b resp=%0d err=%0d", wr_resp, wr_err);
                        chk("wr_resp", wr_resp, exp_b[0]);
                        exp_b.delete(0);
                    end
                end
                acc = req_valid && req_ready;
                bf  = axi.bvalid && axi.bready;
                if (acc && bf) simul_cnt++;
                if (acc && wl) pushpop_cnt++;
                m_out = m_out + int'(acc) - int'(bf);
                m_q   = m_q + int'(acc) - int'(wl);
                if (acc) m_busy = 1'b1;
                else if (awf) m_busy = 1'b0;
                m_done = bf;
                if (bf && axi.bresp != 2'b00) m_err = 1'b1;
                aw_cnt     += int'(awf);
                wl_cnt     += int'(wl);
                w_fire_cnt += int'(wf);
                b_fire_cnt += int'(bf);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        req_valid = 1'b0; req_addr = '0; req_size = '0; req_len = '0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awvalid", axi.awvalid, 1'b0);
        chk("rst_wvalid", axi.wvalid, 1'b0);
        chk("rst_out", outstanding, 3'd0);
        chk("rst_done", wr_done, 1'b0);
        chk("rst_err", wr_err, 1'b0);
        chk("rst_bready", axi.bready, 1'b0);
        chk("rst_awaddr", axi.awaddr, 32'd0);
        reset = 1'b0;

        // single beat
        axi.awready = 1'b1; axi.wready = 1'b1; b_en = 1'b1;
        send_req(32'h1000, 3'd2, 8'd0, 2'b00, 32'hDEADBEEF);
        wait_idle();
        chk("single_out", outstanding, 3'd0);

        // W completes before AW
        axi.awready = 1'b0;
        send_req(32'h2000, 3'd2, 8'd3, 2'b00, $urandom);
        repeat (6) @(negedge clk);
        chk("wfirst_left", exp_w.size(), 0);
        chk("wfirst_awvalid", axi.awvalid, 1'b1);
        chk("wfirst_out", outstanding, 3'd1);
        @(posedge clk); #1;
        axi.awready = 1'b1;
        wait_idle();

        // outstanding limit
        axi.awready = 1'b1; b_en = 1'b0;
        for (int i = 0; i < 4; i++) send_req(32'h3000 + 32'(i * 256), 3'd2, 8'(i), 2'b00, $urandom);
        fork
            send_req(32'h3400, 3'd2, 8'd1, 2'b00, $urandom);
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("lim_ready", req_ready, 1'b0);
                    chk("lim_out", outstanding, 3'd4);
                end
                @(posedge clk); #1;
                b_en = 1'b1;
            end
        join
        @(negedge clk);
        chk("lim_refill_out", outstanding, 3'd4);
        wait_idle();

        // accept and B handshake in the same cycle
        b_en = 1'b0;
        send_req(32'h5000, 3'd2, 8'd0, 2'b00, $urandom);
        repeat (4) @(negedge clk);
        prev = simul_cnt;
        @(negedge clk);
        b_en = 1'b1;
        send_req(32'h5100, 3'd2, 8'd0, 2'b00, $urandom);
        @(negedge clk);
        chk("simul_out", outstanding, 3'd1);
        chk("simul_seen", (simul_cnt > prev), 1'b1);
        wait_idle();

        // len queue push and pop in the same cycle
        prev = pushpop_cnt;
        send_req(32'h6000, 3'd2, 8'd1, 2'b00, $urandom);
        send_req(32'h6100, 3'd2, 8'd2, 2'b00, $urandom);
        wait_idle();
        chk("pushpop_seen", (pushpop_cnt > prev), 1'b1);

        // error response is sticky
        send_req(32'h9000, 3'd2, 8'd1, 2'b00, $urandom);
        send_req(32'h9100, 3'd2, 8'd0, 2'b10, $urandom);
        send_req(32'h9200, 3'd2, 8'd2, 2'b00, $urandom);
        wait_idle();
        chk("err_sticky", wr_err, 1'b1);

        // asynchronous reset mid-burst
        axi.awready = 1'b0;
        send_req(32'hA000, 3'd2, 8'd7, 2'b00, $urandom);
        @(posedge clk); @(posedge clk); #3;
        chk("pre_rst_awvalid", axi.awvalid, 1'b1);
        reset = 1'b1;
        #1;
        chk("arst_awvalid", axi.awvalid, 1'b0);
        chk("arst_wvalid", axi.wvalid, 1'b0);
        chk("arst_out", outstanding, 3'd0);
        chk("arst_err", wr_err, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        axi.awready = 1'b1;
        send_req(32'hB000, 3'd2, 8'd0, 2'b00, $urandom);
        wait_idle();
        chk("post_rst_out", outstanding, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
